mux_gate_exerciser: RTL and testbench
=====================================

Name: mux_gate_exerciser

Overview:
Upstream stimulus-and-check stage for the mux-built 2-input gate blocks (OR/AND/XOR/NAND using a 2:1 mux).
- On a start pulse, drives registered A/B operands through all four input combinations.
- Waits a settle interval per vector, then samples the gate's Y output and compares it against the selected truth table.
- Reports done, pass and a saturating mismatch count.
- Sits between the bench or top-level control and one gate instance.

Parameters:
SETTLE_CYCLES, 2, cycles operands are held before Y is sampled; legal range 1..15
PASSES, 1, number of full 4-vector sweeps per run; legal range 1..8

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to begin a run; ignored unless idle
func_sel  in  2  expected function: 00 OR, 01 AND, 10 XOR, 11 NAND; sampled only when start is accepted
a_out  out  1  operand A to gate under test, registered
b_out  out  1  operand B to gate under test, registered
y_in  in  1  gate output Y, combinational from a_out/b_out
busy  out  1  high from start acceptance until DONE is left
done  out  1  one-cycle pulse at end of run
pass  out  1  1 if err_count==0 at end of run; held until next accepted start
err_count  out  4  mismatches in current/last run, saturates at 15
vector_idx  out  2  current vector, {a_out,b_out}

Behaviour:
- Reset: async assert forces state IDLE. a_out, b_out, busy, done, pass, err_count and vector_idx all go to 0. Settle and pass counters clear.
- Reset mid-run aborts immediately. No done pulse. Results are lost.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: start=1 at an edge goes to DRIVE.
  - On that edge: latch func_sel, idx=0, a_out=b_out=0, err_count=0, pass=0, busy=1, settle counter=0, pass counter=0.
- DRIVE: hold operands for SETTLE_CYCLES cycles (counter 0..SETTLE_CYCLES-1), then go to SAMPLE.
- SAMPLE (1 cycle): compare y_in with expected(func, a_out, b_out).
  - On mismatch, err_count increments, saturating at 15.
  - If idx<3: idx+1, update a_out/b_out = idx+1 bits, go to DRIVE.
  - If idx==3 and pass counter<PASSES-1: increment pass counter, idx wraps to 0, go to DRIVE.
  - Otherwise go to DONE.
- DONE (1 cycle): done=1. pass = (err_count==0). busy drops on exit to IDLE.
- Operand mapping: a_out = idx[1], b_out = idx[0]. Vector order is 00, 01, 10, 11.
- Latency: each vector takes SETTLE_CYCLES+1 cycles. Done is high in the cycle that begins 4*PASSES*(SETTLE_CYCLES+1) edges after the start-accepting edge. With defaults this is 12.
- start while busy (DRIVE/SAMPLE/DONE) is ignored, with no queueing. start in the same cycle DONE is exiting is also ignored.
- A func_sel change mid-run has no effect.
- Outputs hold their last values in IDLE, except done, which is 0.

Optional Feature:
Macro: MUX_GATE_FIRST_FAIL_EN
- Defined: adds outputs first_fail_valid (1b), first_fail_vec (2b) and first_fail_y (1b).
  - On the first mismatch of a run, these capture valid=1, the vector index and the observed y_in.
  - They are not overwritten by later mismatches, clear on accepted start, and reset to 0.
- Undefined: these ports and registers are absent. Behaviour is otherwise identical.

Test Plan:
- Defaults, func_sel=00, correct OR gate connected -> vectors 00,01,10,11 on a_out/b_out. Sampled Y 0,1,1,1. done at edge 12. pass=1, err_count=0.
- func_sel=01 (AND) with OR gate connected -> mismatches at vectors 01 and 10. err_count=2, pass=0. With MUX_GATE_FIRST_FAIL_EN: first_fail_vec=01, first_fail_y=1.
- y_in tied 1, func_sel=11 (NAND), PASSES=8 -> 8 mismatches (vector 11 per pass). err_count=8. done after 96 cycles.
- y_in tied 0, func_sel=00, PASSES=8 -> 24 mismatches. err_count saturates at 15. pass=0.
- start pulsed again in DRIVE, then func_sel toggled -> run unaffected. Exactly one done pulse.
- rst asserted asynchronously mid-DRIVE -> all outputs 0 within the same cycle, state IDLE. A new start then gives a full normal run.

Source files
------------

// File: rtl/mux_gate_exerciser.sv
// ---------------------------------------------------------------------------
// mux_gate_exerciser
//
// Purpose:
//   Stimulus-and-check stage for one mux-built 2-input gate (OR/AND/XOR/NAND).
//   A start pulse begins a run. The run steps registered A/B operands through
//   the four input combinations 00, 01, 10, 11, PASSES times. Each vector is
//   held for SETTLE_CYCLES cycles. The gate output Y is then sampled for one
//   cycle and compared against the truth table chosen by func_sel. At the end
//   the block pulses done, reports pass, and keeps a saturating mismatch count.
//
// Parameters:
//   SETTLE_CYCLES  cycles each vector is held before Y is sampled (1..15)
//   PASSES         number of full 4-vector sweeps per run (1..8)
//
// Optional feature:
//   MUX_GATE_FIRST_FAIL_EN  when defined, first_fail_valid / first_fail_vec /
//                           first_fail_y record the first mismatch of a run.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   single-cycle run request, honoured only in IDLE
//   func_sel    in   00 OR, 01 AND, 10 XOR, 11 NAND; latched when start is taken
//   a_out       out  operand A to the gate (registered)
//   b_out       out  operand B to the gate (registered)
//   y_in        in   gate output Y, combinational from a_out/b_out
//   busy        out  high from start acceptance until DONE is left
//   done        out  one-cycle pulse at the end of a run
//   pass        out  1 when the finished run saw no mismatch; held until next start
//   err_count   out  mismatches in current/last run, saturates at 15
//   vector_idx  out  current vector, equal to {a_out, b_out}
//   dbg_state   out  FSM state (0 IDLE, 1 DRIVE, 2 SAMPLE, 3 DONE)
//
// Handshake: start is a level sampled at the rising edge; it is acted on only
// when the FSM sits in IDLE, and any start seen in DRIVE/SAMPLE/DONE is dropped.
// ---------------------------------------------------------------------------
module mux_gate_exerciser #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] func_sel,
    output logic       a_out,
    output logic       b_out,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [1:0] vector_idx,
`ifdef MUX_GATE_FIRST_FAIL_EN
    output logic       first_fail_valid,
    output logic [1:0] first_fail_vec,
    output logic       first_fail_y,
`endif
    output logic [1:0] dbg_state
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DRIVE  = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] PASS_LAST   = 3'(PASSES - 1);

    logic [1:0] state;
    logic [1:0] func_q;
    logic [3:0] settle_cnt;
    logic [2:0] pass_cnt;

    logic       expected_y;
    logic       mismatch;
    logic [3:0] err_next;

    assign dbg_state = state;

    // Truth table of the selected function for the operands currently driven.
    always_comb begin
        expected_y = 1'b0;
        case (func_q)
            2'b00:   expected_y = a_out | b_out;
            2'b01:   expected_y = a_out & b_out;
            2'b10:   expected_y = a_out ^ b_out;
            default: expected_y = ~(a_out & b_out);
        endcase
    end

    assign mismatch = (state == SAMPLE) && (y_in != expected_y);

    // Count after this cycle's comparison; also feeds pass so a mismatch on
    // the very last vector is reflected in the same edge that enters DONE.
    always_comb begin
        err_next = err_count;
        if (mismatch && (err_count != 4'hf)) begin
            err_next = err_count + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            func_q     <= 2'b00;
            settle_cnt <= 4'd0;
            pass_cnt   <= 3'd0;
            vector_idx <= 2'b00;
            a_out      <= 1'b0;
            b_out      <= 1'b0;
            err_count  <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
`ifdef MUX_GATE_FIRST_FAIL_EN
            first_fail_valid <= 1'b0;
            first_fail_vec   <= 2'b00;
            first_fail_y     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= DRIVE;
                        func_q     <= func_sel;
                        settle_cnt <= 4'd0;
                        pass_cnt   <= 3'd0;
                        vector_idx <= 2'b00;
                        a_out      <= 1'b0;
                        b_out      <= 1'b0;
                        err_count  <= 4'd0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
`ifdef MUX_GATE_FIRST_FAIL_EN
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= 2'b00;
                        first_fail_y     <= 1'b0;
`endif
                    end
                end

                DRIVE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= 4'd0;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end

                SAMPLE: begin
                    err_count <= err_next;
`ifdef MUX_GATE_FIRST_FAIL_EN
                    if (mismatch && !first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_vec   <= vector_idx;
                        first_fail_y     <= y_in;
                    end
`endif
                    if (vector_idx != 2'b11) begin
                        vector_idx <= vector_idx + 2'd1;
                        {a_out, b_out} <= vector_idx + 2'd1;
                        state      <= DRIVE;
                    end else if (pass_cnt != PASS_LAST) begin
                        pass_cnt   <= pass_cnt + 3'd1;
                        vector_idx <= 2'b00;
                        a_out      <= 1'b0;
                        b_out      <= 1'b0;
                        state      <= DRIVE;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                        pass  <= (err_next == 4'd0);
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_gate_exerciser.sv
// ---------------------------------------------------------------------------
// tb_mux_gate_exerciser
//
// Two exerciser instances: lane 0 with PASSES=1, lane 1 with PASSES=8, both
// with SETTLE_CYCLES=2. Each lane drives a behavioural gate (OR/AND/XOR/NAND
// or Y tied 0/1). Runs are issued one at a time. The driver computes the
// expected vector sequence and run result from the truth tables and pushes
// them into queues. Per-lane monitors pop the queues on SAMPLE cycles and on
// done pulses and compare what they see.
// ---------------------------------------------------------------------------
module tb_mux_gate_exerciser;

    localparam int S  = 2;
    localparam int P0 = 1;
    localparam int P1 = 8;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SAMPLE = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- lane signals ----------------
    logic [1:0]      start_s;
    logic [1:0][1:0] func_s;
    int              gmode [2];
    logic [1:0]      a_o, b_o, y_s, busy_o, done_o, pass_o;
    logic [1:0][3:0] err_o;
    logic [1:0][1:0] vec_o, st_o;
`ifdef MUX_GATE_FIRST_FAIL_EN
    logic [1:0]      ffv_o, ffy_o;
    logic [1:0][1:0] ffvec_o;
`endif

    // Behavioural gate under test: 0 OR, 1 AND, 2 XOR, 3 NAND, 4 tied 0, 5 tied 1.
    function automatic logic gate_y(input int m, input logic a, input logic b);
        case (m)
            0:       return a | b;
            1:       return a & b;
            2:       return a ^ b;
            3:       return !(a & b);
            4:       return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign y_s[0] = gate_y(gmode[0], a_o[0], b_o[0]);
    assign y_s[1] = gate_y(gmode[1], a_o[1], b_o[1]);

    mux_gate_exerciser #(.SETTLE_CYCLES(S), .PASSES(P0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .func_sel(func_s[0]),
        .a_out(a_o[0]), .b_out(b_o[0]), .y_in(y_s[0]), .busy(busy_o[0]),
        .done(done_o[0]), .pass(pass_o[0]), .err_count(err_o[0]),
        .vector_idx(vec_o[0]),
`ifdef MUX_GATE_FIRST_FAIL_EN
        .first_fail_valid(ffv_o[0]), .first_fail_vec(ffvec_o[0]),
        .first_fail_y(ffy_o[0]),
`endif
        .dbg_state(st_o[0])
    );

    mux_gate_exerciser #(.SETTLE_CYCLES(S), .PASSES(P1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .func_sel(func_s[1]),
        .a_out(a_o[1]), .b_out(b_o[1]), .y_in(y_s[1]), .busy(busy_o[1]),
        .done(done_o[1]), .pass(pass_o[1]), .err_count(err_o[1]),
        .vector_idx(vec_o[1]),
`ifdef MUX_GATE_FIRST_FAIL_EN
        .first_fail_valid(ffv_o[1]), .first_fail_vec(ffvec_o[1]),
        .first_fail_y(ffy_o[1]),
`endif
        .dbg_state(st_o[1])
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int passes = 0;

    // vec_q entry: {lane, vector}
    logic [2:0]  vec_q[$];
    // res_q entry: {lane, err[3:0], pass, latency[7:0], ff_valid, ff_vec[1:0], ff_y}
    logic [17:0] res_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference truth table written as arithmetic on the operand bits.
    function automatic logic ref_y(input logic [1:0] f, input int v);
        int a, b;
        a = v / 2;
        b = v % 2;
        case (f)
            2'd0:    return (a + b) > 0;
            2'd1:    return (a * b) == 1;
            2'd2:    return (a + b) == 1;
            default: return (a * b) == 0;
        endcase
    endfunction

    // ---------------- monitors ----------------
    for (genvar g = 0; g < 2; g++) begin : mon
        int   lat;
        logic busy_prev;
        logic [2:0]  ve;
        logic [17:0] r;
        always @(negedge clk) begin
            if (rst) begin
                lat = 0;
                busy_prev = 1'b0;
            end else begin
                if (busy_o[g] && !busy_prev) lat = 0;
                else lat++;
                busy_prev = busy_o[g];

                if (st_o[g] == ST_SAMPLE) begin
                    if (vec_q.size() == 0) begin
                        checks++;
                        $display("FAIL vec_unexpected: lane %0d sampled vector %0d, none expected", g, vec_o[g]);
                    end else begin
                        ve = vec_q.pop_front();
                        chk("vec_lane", g, int'(ve[2]));
                        chk("vector_idx", int'(vec_o[g]), int'(ve[1:0]));
                        chk("a_b_out", int'({a_o[g], b_o[g]}), int'(ve[1:0]));
                    end
                end

                if (done_o[g]) begin
                    if (res_q.size() == 0) begin
                        checks++;
                        $display("FAIL done_unexpected: lane %0d done pulse with no run pending", g);
                    end else begin
                        r = res_q.pop_front();
                        chk("res_lane", g, int'(r[17]));
                        chk("err_count", int'(err_o[g]), int'(r[16:13]));
                        chk("pass", int'(pass_o[g]), int'(r[12]));
                        chk("done_latency", lat, int'(r[11:4]));
                        chk("busy_in_done", int'(busy_o[g]), 1);
`ifdef MUX_GATE_FIRST_FAIL_EN
                        chk("ff_valid", int'(ffv_o[g]), int'(r[3]));
                        if (r[3]) begin
                            chk("ff_vec", int'(ffvec_o[g]), int'(r[2:1]));
                            chk("ff_y", int'(ffy_o[g]), int'(r[0]));
                        end
`endif
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk_zero(input int g, input string tag);
        chk({tag, "_a"},     int'(a_o[g]), 0);
        chk({tag, "_b"},     int'(b_o[g]), 0);
        chk({tag, "_busy"},  int'(busy_o[g]), 0);
        chk({tag, "_done"},  int'(done_o[g]), 0);
        chk({tag, "_pass"},  int'(pass_o[g]), 0);
        chk({tag, "_err"},   int'(err_o[g]), 0);
        chk({tag, "_vec"},   int'(vec_o[g]), 0);
        chk({tag, "_state"}, int'(st_o[g]), int'(ST_IDLE));
`ifdef MUX_GATE_FIRST_FAIL_EN
        chk({tag, "_ffv"},   int'(ffv_o[g]), 0);
        chk({tag, "_ffvec"}, int'(ffvec_o[g]), 0);
        chk({tag, "_ffy"},   int'(ffy_o[g]), 0);
`endif
    endtask

    // One complete run on lane g. With spam set, start and func_sel are
    // thrown around while the run is in flight, including on the DONE exit.
    task automatic do_run(input int g, input logic [1:0] f, input int gm, input bit spam);
        int np, errs, exp_lat;
        logic ffv, ffy, obs;
        logic [1:0] ffvec;
        bit seen;
        np = (g == 0) ? P0 : P1;
        gmode[g] = gm;
        errs = 0; ffv = 1'b0; ffy = 1'b0; ffvec = 2'b00;
        for (int p = 0; p < np; p++) begin
            for (int v = 0; v < 4; v++) begin
                vec_q.push_back({g[0], 2'(v)});
                obs = gate_y(gm, v >= 2, (v % 2) == 1);
                if (obs != ref_y(f, v)) begin
                    errs++;
                    if (!ffv) begin
                        ffv = 1'b1; ffvec = 2'(v); ffy = obs;
                    end
                end
            end
        end
        if (errs > 15) errs = 15;
        exp_lat = 4 * np * (S + 1);
        res_q.push_back({g[0], 4'(errs), (errs == 0), 8'(exp_lat), ffv, ffvec, ffy});

        func_s[g] = f;
        start_s[g] = 1'b1;
        @(negedge clk);
        start_s[g] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            if (spam) begin
                start_s[g] = ($urandom_range(0, 2) == 0);
                func_s[g]  = 2'($urandom_range(0, 3));
            end
            @(negedge clk);
            if (done_o[g]) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            $display("FAIL done_timeout: lane %0d no done within 400 cycles", g);
        end
        start_s[g] = spam;
        @(negedge clk);
        start_s[g] = 1'b0;
        chk("idle_after_done", int'(st_o[g]), int'(ST_IDLE));
        chk("busy_after_done", int'(busy_o[g]), 0);
        @(negedge clk);
        chk("done_low_idle", int'(done_o[g]), 0);
        chk("pass_held", int'(pass_o[g]), int'(errs == 0));
        chk("err_held", int'(err_o[g]), errs);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        start_s = '0;
        func_s = '0;
        gmode[0] = 0;
        gmode[1] = 0;
        repeat (3) @(negedge clk);
        chk_zero(0, "reset0");
        chk_zero(1, "reset1");
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        do_run(0, 2'b00, 0, 1'b0);   // OR vs OR gate: clean, done at 12
        do_run(0, 2'b01, 0, 1'b0);   // AND vs OR gate: 2 mismatches, first at 01
        do_run(1, 2'b11, 5, 1'b0);   // NAND vs Y=1, 8 passes: 8 mismatches, 96 cycles
        do_run(1, 2'b00, 4, 1'b0);   // OR vs Y=0, 8 passes: 24 -> saturates at 15
        do_run(0, 2'b10, 2, 1'b1);   // XOR clean while start/func_sel are thrown around
        do_run(1, 2'b01, 1, 1'b1);

        // Random runs
        for (int i = 0; i < 12; i++) begin
            do_run(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a run on lane 0 (Y tied 1, OR).
        gmode[0] = 5;
        func_s[0] = 2'b00;
        vec_q.push_back(3'b000);     // vector 00 is sampled once before the abort
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_err", int'(err_o[0]), 1);
        chk("pre_rst_vec", int'(vec_o[0]), 1);
        chk("pre_rst_busy", int'(busy_o[0]), 1);
        #2;
        rst = 1'b1;
        #1;
        chk_zero(0, "midrun_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_run(0, 2'b00, 0, 1'b0);   // full normal run after the abort

        repeat (3) @(negedge clk);
        chk("vec_q_empty", vec_q.size(), 0);
        chk("res_q_empty", res_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
